s2d_sched: RTL and testbench
============================

# s2d_sched

Scheduler and dense-RAM port owner for the sparse-to-dense conversion stage of KeyGen. On `start` it zero-fills the shared dense RAM, then runs the `sparse2dense` converter once per polynomial (h0, then h1), steering the converter's sparse/dense addresses into per-polynomial regions. It also grants a host read port to the dense RAM while idle, and aborts a hung conversion via a watchdog.

## Interface
- `DSN_ADDR_W`, 9: shared dense RAM address width.
- `G_ADDR_W`, 8: converter dense address width.
- `G_DAT_W`, 64: dense word width.
- `H_ADDR_W`, 7: converter sparse address width.
- `DSN_STRIDE`, 160: dense words per polynomial region (≥ ceil(r/64)=159).
- `NUM_POLY`, 2: polynomials converted per run.
- `TIMEOUT`, 2048: max cycles from `s2d_start` to `s2d_done`.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE.
- `busy`  out  1  high from the cycle after accepted `start` through FIN.
- `done`  out  1  one-cycle pulse at end of run.
- `err`  out  1  sticky timeout flag; cleared by next accepted `start`.
- `s2d_rst_b`  out  1  converter reset, active-low: `~(rst | abort)`.
- `s2d_start`  out  1  one-cycle converter start pulse.
- `s2d_done`  in  1  converter done pulse.
- `s2d_spa_addr`  in  H_ADDR_W  converter sparse address.
- `s2d_dsn_addr`  in  G_ADDR_W  converter dense address.
- `s2d_dsn_we`  in  1  converter dense write enable.
- `s2d_dsn_wdata`  in  G_DAT_W  converter dense write data.
- `spa_addr`  out  H_ADDR_W+1  sparse RAM address `{poly, s2d_spa_addr}`.
- `dsn_addr`  out  DSN_ADDR_W  shared dense RAM address.
- `dsn_we`  out  1  shared dense RAM write enable.
- `dsn_wdata`  out  G_DAT_W  shared dense RAM write data.
- `hst_req`  in  1  host read request.
- `hst_addr`  in  DSN_ADDR_W  host read address.
- `hst_gnt`  out  1  host owns dense port (combinational: state==IDLE).

Dense read data returns directly from the RAM to the converter and host; it is not muxed here.

## Operation
- States: IDLE, CLR, CSTART, CWAIT, DRAIN, FIN.
- IDLE: dense port carries `hst_addr`, `dsn_we`=0. `start`=1 moves to CLR, clears `err`, and sets `clr_addr`=0 and `poly`=0.
- CLR: drives `dsn_addr`=`clr_addr`, `dsn_we`=1, `dsn_wdata`=0, and increments each cycle. After address NUM_POLY*DSN_STRIDE−1 it moves to CSTART.
- CSTART: `s2d_start`=1 for one cycle, watchdog loads 0, then CWAIT.
- CWAIT/DRAIN: dense port is muxed from the converter.
  - `dsn_addr` = `poly*DSN_STRIDE + s2d_dsn_addr`, zero-extended.
  - `dsn_we` = `s2d_dsn_we`; `dsn_wdata` = `s2d_dsn_wdata`.
- CWAIT exit on `s2d_done`=1: go to DRAIN.
- DRAIN: lasts exactly 2 cycles, because the converter's final write-back lands after its done pulse. Then:
  - if `poly`<NUM_POLY−1: `poly`++, go to CSTART;
  - otherwise go to FIN.
- Watchdog: counts in CWAIT. Reaching TIMEOUT sets `err`=1, pulses `abort` for one cycle (so `s2d_rst_b`=0), and jumps to FIN, skipping remaining polynomials.
- FIN: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored. `s2d_done` outside CWAIT is ignored.
- `hst_req` outside IDLE is not granted. The host must hold the request until `hst_gnt`.

## Timing
- Reset values: state IDLE; `busy`, `done`, `err`, `s2d_start`, `abort`, `dsn_we` = 0; `poly`, `clr_addr`, watchdog = 0; `s2d_rst_b`=0 while `rst`.
- `rst` mid-run: next cycle is IDLE with all outputs at reset values. The converter is reset concurrently through `s2d_rst_b`. No further dense writes occur.
- `start` at cycle t: first clear write at t+1; last clear write at t+NUM_POLY*DSN_STRIDE (t+320); `s2d_start` at t+321.
- `s2d_done` seen at cycle d: DRAIN at d+1 and d+2; next `s2d_start` or FIN at d+3. `done` rises one cycle after FIN entry.
- The converter-path mux is combinational and adds zero latency. All control outputs are registered.

## Structure
- Package `s2d_pkg`: state enum, `NUM_POLY`, `DSN_STRIDE`, and `DRAIN_CYC`=2.
- No sub-module. The watchdog, clear counter and port mux are in-line. The converter is instantiated beside this block at KeyGen top.

## Test plan
- Reset, then `start` with a converter model that raises done after 700 cycles: 320 zero writes at addresses 0..319; `s2d_start` at t+321; then a second `s2d_start`; `done` pulse; `err`=0.
- Converter writes `s2d_dsn_addr`=5 during poly 1 → `dsn_addr`=165, `dsn_we`=1, data passed unchanged. `spa_addr` MSB=1.
- Converter write issued 1 cycle after its `s2d_done` → still reaches the RAM during DRAIN.
- Converter never asserts done → after 2048 cycles `err`=1, `s2d_rst_b` low for 1 cycle, `done` pulses, no second `s2d_start`.
- `hst_req` during CLR → `hst_gnt`=0 until IDLE. `start` during CWAIT is ignored.
- `rst` at clear address 100 → `dsn_we`=0 next cycle, `busy`=0. A fresh `start` restarts clearing at address 0.

Source files
------------

// File: rtl/s2d_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | s2d_pkg : shared types and constants for the sparse-to-dense scheduler    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package s2d_pkg;

  localparam int NUM_POLY   = 2;
  localparam int DSN_STRIDE = 160;
  localparam int DRAIN_CYC  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_CSTART = 3'd2,
    ST_CWAIT  = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_FIN    = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/s2d_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | s2d_sched : zero-fills the dense RAM, then sequences the sparse2dense    |
// | converter over each polynomial region; owns the dense RAM port.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module s2d_sched #(
  parameter int DSN_ADDR_W = 9,
  parameter int G_ADDR_W   = 8,
  parameter int G_DAT_W    = 64,
  parameter int H_ADDR_W   = 7,
  parameter int DSN_STRIDE = s2d_pkg::DSN_STRIDE,
  parameter int NUM_POLY   = s2d_pkg::NUM_POLY,
  parameter int TIMEOUT    = 2048
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  s2d_rst_b,
  output logic                  s2d_start,
  input  logic                  s2d_done,
  input  logic [H_ADDR_W-1:0]   s2d_spa_addr,
  input  logic [G_ADDR_W-1:0]   s2d_dsn_addr,
  input  logic                  s2d_dsn_we,
  input  logic [G_DAT_W-1:0]    s2d_dsn_wdata,
  output logic [H_ADDR_W:0]     spa_addr,
  output logic [DSN_ADDR_W-1:0] dsn_addr,
  output logic                  dsn_we,
  output logic [G_DAT_W-1:0]    dsn_wdata,
  input  logic                  hst_req,
  input  logic [DSN_ADDR_W-1:0] hst_addr,
  output logic                  hst_gnt
);

  import s2d_pkg::*;

  localparam int WD_W     = $clog2(TIMEOUT + 1);
  localparam int CLR_LAST = NUM_POLY * DSN_STRIDE - 1;

  state_e                state_q, state_d;
  logic [DSN_ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic                  poly_q, poly_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic                  drn_q, drn_d;
  logic                  err_q, err_d;
  logic                  busy_q, done_q, s2d_start_q, abort_q;
  logic                  timeout_hit;
  logic [DSN_ADDR_W-1:0] cnv_addr;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    poly_d      = poly_q;
    wd_d        = wd_q;
    drn_d       = drn_q;
    err_d       = err_q;
    timeout_hit = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_CLR;
          clr_addr_d = '0;
          poly_d     = 1'b0;
          err_d      = 1'b0;
        end
      end
      ST_CLR: begin
        if (clr_addr_q == DSN_ADDR_W'(CLR_LAST)) begin
          state_d = ST_CSTART;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      ST_CSTART: begin
        wd_d    = '0;
        state_d = ST_CWAIT;
      end
      ST_CWAIT: begin
        // A done arriving on the final watchdog cycle still counts as success
        if (s2d_done) begin
          state_d = ST_DRAIN;
          drn_d   = 1'b0;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          err_d       = 1'b1;
          state_d     = ST_FIN;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drn_q == 1'(DRAIN_CYC - 1)) begin
          if (int'(poly_q) < NUM_POLY - 1) begin
            poly_d  = poly_q + 1'b1;
            state_d = ST_CSTART;
          end else begin
            state_d = ST_FIN;
          end
        end else begin
          drn_d = drn_q + 1'b1;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_addr_q  <= '0;
      poly_q      <= 1'b0;
      wd_q        <= '0;
      drn_q       <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      s2d_start_q <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      clr_addr_q  <= clr_addr_d;
      poly_q      <= poly_d;
      wd_q        <= wd_d;
      drn_q       <= drn_d;
      err_q       <= err_d;
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_q == ST_FIN);
      s2d_start_q <= (state_d == ST_CSTART);
      abort_q     <= timeout_hit;
    end
  end

  assign cnv_addr = DSN_ADDR_W'(poly_q) * DSN_ADDR_W'(DSN_STRIDE)
                  + DSN_ADDR_W'(s2d_dsn_addr);

  // Dense port owner: host while idle, clear counter, then converter
  always_comb begin
    dsn_addr  = '0;
    dsn_we    = 1'b0;
    dsn_wdata = '0;
    unique case (state_q)
      ST_IDLE: begin
        dsn_addr = hst_req ? hst_addr : '0;
      end
      ST_CLR: begin
        dsn_addr = clr_addr_q;
        dsn_we   = 1'b1;
      end
      ST_CWAIT, ST_DRAIN: begin
        dsn_addr  = cnv_addr;
        dsn_we    = s2d_dsn_we;
        dsn_wdata = s2d_dsn_wdata;
      end
      default: begin
        dsn_addr = '0;
      end
    endcase
  end

  assign spa_addr  = {poly_q, s2d_spa_addr};
  assign hst_gnt   = (state_q == ST_IDLE);
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign s2d_start = s2d_start_q;
  assign s2d_rst_b = ~(rst | abort_q);

endmodule
`default_nettype wire

// File: tb/tb_s2d_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_s2d_sched : directed bench with dense-write scoreboard for s2d_sched  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_s2d_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        s2d_done = 1'b0;
  logic [6:0]  s2d_spa_addr = '0;
  logic [7:0]  s2d_dsn_addr = '0;
  logic        s2d_dsn_we = 1'b0;
  logic [63:0] s2d_dsn_wdata = '0;
  logic        hst_req = 1'b0;
  logic [8:0]  hst_addr = '0;

  logic        busy, done, err, s2d_rst_b, s2d_start;
  logic [7:0]  spa_addr;
  logic [8:0]  dsn_addr;
  logic        dsn_we;
  logic [63:0] dsn_wdata;
  logic        hst_gnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int start_cnt = 0, done_cnt = 0, abort_cnt = 0, abort_cyc = 0;
  int c0, c1;
  logic [72:0] sb[$];
  logic [72:0] exp_wr;

  s2d_sched dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .s2d_rst_b(s2d_rst_b), .s2d_start(s2d_start), .s2d_done(s2d_done),
    .s2d_spa_addr(s2d_spa_addr), .s2d_dsn_addr(s2d_dsn_addr),
    .s2d_dsn_we(s2d_dsn_we), .s2d_dsn_wdata(s2d_dsn_wdata),
    .spa_addr(spa_addr), .dsn_addr(dsn_addr), .dsn_we(dsn_we),
    .dsn_wdata(dsn_wdata), .hst_req(hst_req), .hst_addr(hst_addr),
    .hst_gnt(hst_gnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus sampled at the negedge is what the RAM captures on the next posedge
  task automatic tick();
    @(negedge clk);
    if (dsn_we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("wr_unexpected", dsn_we, 1'b0);
      end else begin
        exp_wr = sb.pop_front();
        chk("dense_wr", {dsn_addr, dsn_wdata}, exp_wr);
      end
    end
    if (s2d_start === 1'b1) start_cnt++;
    if (done === 1'b1) done_cnt++;
    if (s2d_rst_b === 1'b0 && rst === 1'b0) begin
      abort_cnt++;
      abort_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_clears();
    for (int k = 0; k < 320; k++) sb.push_back({9'(k), 64'd0});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    #1;
    repeat (3) tick();
    chk("rst_s2d_rst_b", s2d_rst_b, 1'b0);
    rst = 1'b0;
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_s2d_start", s2d_start, 1'b0);
    chk("rst_dsn_we", dsn_we, 1'b0);
    chk("rst_rst_b_rel", s2d_rst_b, 1'b1);
    hst_req = 1'b1;
    hst_addr = 9'h1AB;
    tick();
    chk("idle_gnt", hst_gnt, 1'b1);
    chk("idle_hst_addr", dsn_addr, 9'h1AB);

    // ---- Run 1: normal two-polynomial conversion ----
    start_cnt = 0;
    done_cnt = 0;
    start = 1'b1;
    push_clears();
    tick();
    start = 1'b0;
    chk("busy_rise", busy, 1'b1);
    chk("gnt_in_clr", hst_gnt, 1'b0);
    repeat (319) tick();
    chk("clr_last_addr", dsn_addr, 9'd319);
    chk("no_start_in_clr", s2d_start, 1'b0);
    tick();
    chk("s2d_start_t321", s2d_start, 1'b1);
    chk("clr_all_written", sb.size(), 0);
    tick();
    chk("s2d_start_pulse", s2d_start, 1'b0);
    repeat (8) tick();
    s2d_dsn_we = 1'b1;
    s2d_dsn_addr = 8'd7;
    s2d_dsn_wdata = 64'hDEAD_BEEF_0123_4567;
    sb.push_back({9'd7, 64'hDEAD_BEEF_0123_4567});
    tick();
    s2d_dsn_we = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_cwait_busy", busy, 1'b1);
    chk("start_in_cwait_no_pulse", s2d_start, 1'b0);
    repeat (689) tick();
    s2d_done = 1'b1;
    tick();
    s2d_done = 1'b0;
    s2d_dsn_we = 1'b1;
    s2d_dsn_addr = 8'd3;
    s2d_dsn_wdata = 64'h0F0F_AAAA_5555_F0F0;
    sb.push_back({9'd3, 64'h0F0F_AAAA_5555_F0F0});
    tick();
    s2d_dsn_we = 1'b0;
    chk("drain_no_start", s2d_start, 1'b0);
    tick();
    chk("s2d_start_poly1", s2d_start, 1'b1);
    chk("drain_wr_landed", sb.size(), 0);
    tick();
    s2d_spa_addr = 7'h2A;
    s2d_dsn_we = 1'b1;
    s2d_dsn_addr = 8'd5;
    s2d_dsn_wdata = 64'h1234_5678_9ABC_DEF0;
    sb.push_back({9'd165, 64'h1234_5678_9ABC_DEF0});
    #1;
    chk("poly1_spa_addr", spa_addr, 8'hAA);
    chk("poly1_dsn_addr", dsn_addr, 9'd165);
    tick();
    s2d_dsn_we = 1'b0;
    repeat (48) tick();
    s2d_done = 1'b1;
    tick();
    s2d_done = 1'b0;
    repeat (2) tick();
    chk("fin_done_low", done, 1'b0);
    tick();
    chk("done_pulse", done, 1'b1);
    chk("done_busy_low", busy, 1'b0);
    chk("done_err", err, 1'b0);
    chk("done_gnt", hst_gnt, 1'b1);
    tick();
    chk("done_one_cycle", done, 1'b0);
    chk("run1_starts", start_cnt, 2);
    chk("run1_sb_empty", sb.size(), 0);

    // ---- Run 2: converter hangs, watchdog aborts ----
    start = 1'b1;
    push_clears();
    tick();
    start = 1'b0;
    repeat (320) tick();
    chk("to_s2d_start", s2d_start, 1'b1);
    c0 = cyc;
    start_cnt = 0;
    done_cnt = 0;
    abort_cnt = 0;
    for (int i = 0; i < 2200 && done_cnt == 0; i++) begin
      tick();
      if (cyc == c0 + 2000) chk("to_err_early", err, 1'b0);
    end
    chk("to_done_seen", done_cnt, 1);
    chk("to_err", err, 1'b1);
    chk("to_abort_pulses", abort_cnt, 1);
    chk("to_abort_time", ((abort_cyc - c0) >= 2048 && (abort_cyc - c0) <= 2050), 1'b1);
    chk("to_no_2nd_start", start_cnt, 1);

    // ---- Run 3: reset in the middle of clearing ----
    start = 1'b1;
    push_clears();
    tick();
    start = 1'b0;
    chk("err_clr_on_start", err, 1'b0);
    repeat (100) tick();
    chk("clr_addr_100", dsn_addr, 9'd100);
    rst = 1'b1;
    tick();
    chk("midrst_dsn_we", dsn_we, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_gnt", hst_gnt, 1'b1);
    chk("midrst_rst_b", s2d_rst_b, 1'b0);
    rst = 1'b0;
    sb.delete();
    repeat (3) tick();
    chk("after_rst_idle", busy, 1'b0);

    // ---- Run 4: fresh start clears from address 0 ----
    start_cnt = 0;
    done_cnt = 0;
    start = 1'b1;
    push_clears();
    tick();
    start = 1'b0;
    repeat (320) tick();
    chk("r4_s2d_start", s2d_start, 1'b1);
    repeat (10) tick();
    s2d_done = 1'b1;
    tick();
    s2d_done = 1'b0;
    repeat (2) tick();
    chk("r4_s2d_start2", s2d_start, 1'b1);
    repeat (10) tick();
    s2d_done = 1'b1;
    tick();
    s2d_done = 1'b0;
    c1 = 0;
    while (done_cnt == 0 && c1 < 20) begin
      tick();
      c1++;
    end
    chk("r4_done", done_cnt, 1);
    chk("r4_err", err, 1'b0);
    chk("r4_sb_empty", sb.size(), 0);
    chk("r4_starts", start_cnt, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
